// File: rtl/riscv_proc_dpath_ex_result.sv
// Execute-stage result stage: resolves conditional branches into a registered
// redirect and queues register writes in a two-entry skid buffer with bypass.
module riscv_proc_dpath_ex_result #(
    parameter int XLEN      = 64,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ex_val,
    input  logic                 ex_kill,
    output logic                 ex_rdy,
    input  logic [2:0]           ex_br_type,
    input  logic [XLEN-1:0]      ex_alu_out,
    input  logic                 ex_lt,
    input  logic                 ex_ltu,
    input  logic [XLEN-1:0]      ex_br_target,
    input  logic                 ex_wen,
    input  logic [NREG_BITS-1:0] ex_waddr,
    input  logic [XLEN-1:0]      ex_wdata,
    output logic                 br_taken,
    output logic [XLEN-1:0]      br_target,
    output logic                 wb_val,
    input  logic                 wb_rdy,
    output logic [NREG_BITS-1:0] wb_waddr,
    output logic [XLEN-1:0]      wb_wdata,
    output logic [1:0]           byp_val,
    output logic [NREG_BITS-1:0] byp_waddr0,
    output logic [NREG_BITS-1:0] byp_waddr1,
    output logic [XLEN-1:0]      byp_wdata0,
    output logic [XLEN-1:0]      byp_wdata1
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t            state, state_nxt;
    logic [NREG_BITS-1:0]  head_waddr, head_waddr_nxt;
    logic [NREG_BITS-1:0]  skid_waddr, skid_waddr_nxt;
    logic [XLEN-1:0]       head_wdata, head_wdata_nxt;
    logic [XLEN-1:0]       skid_wdata, skid_wdata_nxt;

    logic accept, enq, deq, eq, taken;

    // ex_rdy decodes registered state only, so it never depends on wb_rdy.
    assign ex_rdy = (state != BUF_TWO);
    assign wb_val = (state != BUF_EMPTY);

    assign accept = ex_val & ex_rdy & ~ex_kill;
    assign enq    = accept & ex_wen & (ex_waddr != '0);
    assign deq    = wb_val & wb_rdy;
    assign eq     = (ex_alu_out == '0);

    always_comb begin
        taken = 1'b0;
        case (ex_br_type)
            3'd0: taken = 1'b0;
            3'd1: taken = eq;
            3'd2: taken = ~eq;
            3'd3: taken = ex_lt;
            3'd4: taken = ~ex_lt;
            3'd5: taken = ex_ltu;
            3'd6: taken = ~ex_ltu;
            3'd7: taken = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_taken  <= 1'b0;
            br_target <= '0;
        end else begin
            br_taken <= accept & taken;
            if (accept & taken) begin
                br_target <= ex_br_target;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        head_waddr_nxt = head_waddr;
        head_wdata_nxt = head_wdata;
        skid_waddr_nxt = skid_waddr;
        skid_wdata_nxt = skid_wdata;
        case (state)
            BUF_EMPTY: begin
                if (enq) begin
                    state_nxt      = BUF_ONE;
                    head_waddr_nxt = ex_waddr;
                    head_wdata_nxt = ex_wdata;
                end
            end
            BUF_ONE: begin
                if (enq && deq) begin
                    head_waddr_nxt = ex_waddr;
                    head_wdata_nxt = ex_wdata;
                end else if (enq) begin
                    state_nxt      = BUF_TWO;
                    skid_waddr_nxt = ex_waddr;
                    skid_wdata_nxt = ex_wdata;
                end else if (deq) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                // The skid entry is younger; it becomes the head once the head drains.
                if (deq) begin
                    state_nxt      = BUF_ONE;
                    head_waddr_nxt = skid_waddr;
                    head_wdata_nxt = skid_wdata;
                    skid_waddr_nxt = '0;
                    skid_wdata_nxt = '0;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BUF_EMPTY;
            head_waddr <= '0;
            head_wdata <= '0;
            skid_waddr <= '0;
            skid_wdata <= '0;
        end else begin
            state      <= state_nxt;
            head_waddr <= head_waddr_nxt;
            head_wdata <= head_wdata_nxt;
            skid_waddr <= skid_waddr_nxt;
            skid_wdata <= skid_wdata_nxt;
        end
    end

    assign wb_waddr   = head_waddr;
    assign wb_wdata   = head_wdata;
    assign byp_val    = {state == BUF_TWO, state != BUF_EMPTY};
    assign byp_waddr0 = head_waddr;
    assign byp_wdata0 = head_wdata;
    assign byp_waddr1 = skid_waddr;
    assign byp_wdata1 = skid_wdata;

endmodule
